cvxif_copro_issue_ctrl: RTL and testbench

//   Parametrised CV-X-IF coprocessor front end: decodes offloaded instructions against a

---
 rtl/cvxif_copro_issue_ctrl.sv | 191 +++++++++++++++++++
 tb/tb_cvxif_copro_issue_ctrl.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cvxif_copro_issue_ctrl.sv
// CV-X-IF coprocessor front end: mask/match decode, issue/commit/result handshakes,
// and an in-order in-flight buffer that returns each op once committed and aged.
module cvxif_copro_issue_ctrl #(
    parameter int unsigned XLEN     = 32,
    parameter int unsigned NR_RS    = 3,
    parameter int unsigned ID_W     = 3,
    parameter int unsigned DEPTH    = 4,
    parameter int unsigned EXEC_LAT = 2
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    input  logic                    issue_valid_i,
    output logic                    issue_ready_o,
    input  logic [31:0]             issue_instr_i,
    input  logic [ID_W-1:0]         issue_id_i,
    input  logic [NR_RS*XLEN-1:0]   issue_rs_i,
    input  logic [NR_RS-1:0]        issue_rs_valid_i,
    output logic                    issue_accept_o,
    output logic                    issue_writeback_o,
    output logic [NR_RS-1:0]        issue_regread_o,
    input  logic                    commit_valid_i,
    input  logic [ID_W-1:0]         commit_id_i,
    input  logic                    commit_kill_i,
    output logic                    result_valid_o,
    input  logic                    result_ready_i,
    output logic [ID_W-1:0]         result_id_o,
    output logic [4:0]              result_rd_o,
    output logic [XLEN-1:0]         result_data_o,
    output logic                    result_we_o,
    output logic                    busy_o
);

    localparam int unsigned PW  = $clog2(DEPTH);
    localparam int unsigned CW  = $clog2(EXEC_LAT + 1);
    localparam int unsigned SHW = $clog2(2 * XLEN);

    typedef struct packed {
        logic            valid;
        logic [ID_W-1:0] id;
        logic [4:0]      rd;
        logic [XLEN-1:0] data;
        logic [CW-1:0]   cnt;
        logic            committed;
        logic            killed;
    } entry_t;

    entry_t          buf_q [DEPTH];
    entry_t          buf_d [DEPTH];
    logic [PW-1:0]   head_q, head_d, tail_q, tail_d;
    logic [PW:0]     count_q, count_d;
    logic            res_valid_q, res_valid_d;
    logic [ID_W-1:0] res_id_q, res_id_d;
    logic [4:0]      res_rd_q, res_rd_d;
    logic [XLEN-1:0] res_data_q, res_data_d;
    logic            busy_q;

    logic [3*XLEN-1:0] rs_ext;
    logic [XLEN-1:0]   rs1, rs2, rs3, op_data;
    logic [2*XLEN-1:0] cat, rot;
    logic [SHW-1:0]    shamt;
    logic [2:0]        rr3;
    logic              dec_accept, dec_wb;
    logic              id_hit, kill_after_commit, full, push, pop, kill_head;

    // Decode and execute; first matching table row wins
    always_comb begin
        rs_ext  = (3*XLEN)'(issue_rs_i);
        rs1     = rs_ext[0 +: XLEN];
        rs2     = rs_ext[XLEN +: XLEN];
        rs3     = rs_ext[2*XLEN +: XLEN];
        cat     = {rs1, rs2};
        shamt   = issue_instr_i[25 +: SHW];
        for (int i = 0; i < 2*XLEN; i++) begin
            rot[i] = cat[SHW'(i) + shamt];
        end
        dec_accept = 1'b0;
        dec_wb     = 1'b0;
        rr3        = 3'b000;
        op_data    = '0;
        if ((issue_instr_i & 32'hFE00707F) == 32'h0000007B) begin
            dec_accept = 1'b1;
        end else if ((issue_instr_i & 32'hFE00707F) == 32'h0000107B) begin
            dec_accept = 1'b1; dec_wb = 1'b1; rr3 = 3'b011; op_data = rs1 + rs2;
        end else if ((issue_instr_i & 32'hFE00707F) == 32'h0200107B) begin
            dec_accept = 1'b1; dec_wb = 1'b1; rr3 = 3'b001; op_data = rs1 + rs1;
        end else if ((issue_instr_i & 32'hFE00707F) == 32'h0400107B) begin
            dec_accept = 1'b1; dec_wb = 1'b1; rr3 = 3'b010; op_data = rs2 + rs2;
        end else if ((NR_RS == 3) && ((issue_instr_i & 32'hFE00707F) == 32'h0800107B)) begin
            dec_accept = 1'b1; dec_wb = 1'b1; rr3 = 3'b111; op_data = rs1 + rs2 + rs3;
        end else if ((issue_instr_i & 32'h0000707F) == 32'h0000000B) begin
            dec_accept = 1'b1; dec_wb = 1'b1; rr3 = 3'b011; op_data = rot[2*XLEN-1 -: XLEN];
        end else if ((issue_instr_i & 32'h0000707F) == 32'h0000100B) begin
            dec_accept = 1'b1; dec_wb = 1'b1; rr3 = 3'b011; op_data = rot[XLEN-1:0];
        end
    end

    assign issue_accept_o    = dec_accept;
    assign issue_writeback_o = dec_wb;
    assign issue_regread_o   = NR_RS'(rr3);

    // Id lookups against live entries
    always_comb begin
        id_hit            = 1'b0;
        kill_after_commit = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (buf_q[i].valid && buf_q[i].id == issue_id_i) id_hit = 1'b1;
            if (buf_q[i].valid && buf_q[i].id == commit_id_i && buf_q[i].committed)
                kill_after_commit = 1'b1;
        end
    end

    assign full          = (count_q == (PW+1)'(DEPTH));
    assign issue_ready_o = issue_valid_i & ~full & ~id_hit &
                           (~dec_accept | ((issue_regread_o & issue_rs_valid_i) == issue_regread_o));

    // Buffer next state: age, commit/kill, pop head, push tail, then derive the next result
    always_comb begin
        for (int i = 0; i < DEPTH; i++) buf_d[i] = buf_q[i];
        head_d    = head_q;
        tail_d    = tail_q;
        push      = issue_ready_o & dec_accept & dec_wb;
        kill_head = commit_valid_i & commit_kill_i & buf_q[head_q].valid &
                    (buf_q[head_q].id == commit_id_i) & ~buf_q[head_q].committed;
        pop       = (res_valid_q & result_ready_i) |
                    (buf_q[head_q].valid & ~res_valid_q & (buf_q[head_q].killed | kill_head));
        for (int i = 0; i < DEPTH; i++) begin
            if (buf_q[i].valid && buf_q[i].cnt != '0) buf_d[i].cnt = buf_q[i].cnt - CW'(1);
            if (commit_valid_i && buf_q[i].valid && buf_q[i].id == commit_id_i &&
                !buf_q[i].committed && !buf_q[i].killed) begin
                if (commit_kill_i) buf_d[i].killed    = 1'b1;
                else               buf_d[i].committed = 1'b1;
            end
        end
        if (pop) begin
            buf_d[head_q] = '0;
            head_d        = head_q + 1'b1;
        end
        if (push) begin
            buf_d[tail_q].valid     = 1'b1;
            buf_d[tail_q].id        = issue_id_i;
            buf_d[tail_q].rd        = issue_instr_i[11:7];
            buf_d[tail_q].data      = op_data;
            buf_d[tail_q].cnt       = CW'(EXEC_LAT);
            buf_d[tail_q].committed = commit_valid_i & (commit_id_i == issue_id_i) & ~commit_kill_i;
            buf_d[tail_q].killed    = commit_valid_i & (commit_id_i == issue_id_i) & commit_kill_i;
            tail_d                  = tail_q + 1'b1;
        end
        count_d     = count_q + (PW+1)'(push) - (PW+1)'(pop);
        res_valid_d = buf_d[head_d].valid & buf_d[head_d].committed &
                      ~buf_d[head_d].killed & (buf_d[head_d].cnt == '0);
        res_id_d    = res_valid_d ? buf_d[head_d].id   : '0;
        res_rd_d    = res_valid_d ? buf_d[head_d].rd   : '0;
        res_data_d  = res_valid_d ? buf_d[head_d].data : '0;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < DEPTH; i++) buf_q[i] <= '0;
            head_q      <= '0;
            tail_q      <= '0;
            count_q     <= '0;
            res_valid_q <= 1'b0;
            res_id_q    <= '0;
            res_rd_q    <= '0;
            res_data_q  <= '0;
            busy_q      <= 1'b0;
        end else begin
            for (int i = 0; i < DEPTH; i++) buf_q[i] <= buf_d[i];
            head_q      <= head_d;
            tail_q      <= tail_d;
            count_q     <= count_d;
            res_valid_q <= res_valid_d;
            res_id_q    <= res_id_d;
            res_rd_q    <= res_rd_d;
            res_data_q  <= res_data_d;
            busy_q      <= (count_d != '0);
        end
    end

    assign result_valid_o = res_valid_q;
    assign result_id_o    = res_id_q;
    assign result_rd_o    = res_rd_q;
    assign result_data_o  = res_data_q;
    assign result_we_o    = res_valid_q;
    assign busy_o         = busy_q;

    // Killing an already-committed op is a core protocol error; the kill is ignored
    kill_after_commit_a: assert property (@(posedge clk_i) disable iff (!rst_ni)
        !(commit_valid_i && commit_kill_i && kill_after_commit));

endmodule

// File: tb/tb_cvxif_copro_issue_ctrl.sv
// Directed bench for cvxif_copro_issue_ctrl: decode/execute vector table plus
// hand-written sequences for fill, kill ordering, kill-at-head and mid-flight reset.
module tb_cvxif_copro_issue_ctrl;

    logic        clk_i = 1'b0;
    logic        rst_ni;
    logic        issue_valid_i;
    logic        issue_ready_o;
    logic [31:0] issue_instr_i;
    logic [2:0]  issue_id_i;
    logic [95:0] issue_rs_i;
    logic [2:0]  issue_rs_valid_i;
    logic        issue_accept_o;
    logic        issue_writeback_o;
    logic [2:0]  issue_regread_o;
    logic        commit_valid_i;
    logic [2:0]  commit_id_i;
    logic        commit_kill_i;
    logic        result_valid_o;
    logic        result_ready_i;
    logic [2:0]  result_id_o;
    logic [4:0]  result_rd_o;
    logic [31:0] result_data_o;
    logic        result_we_o;
    logic        busy_o;

    int checks   = 0;
    int failures = 0;

    cvxif_copro_issue_ctrl dut (
        .clk_i(clk_i), .rst_ni(rst_ni),
        .issue_valid_i(issue_valid_i), .issue_ready_o(issue_ready_o),
        .issue_instr_i(issue_instr_i), .issue_id_i(issue_id_i),
        .issue_rs_i(issue_rs_i), .issue_rs_valid_i(issue_rs_valid_i),
        .issue_accept_o(issue_accept_o), .issue_writeback_o(issue_writeback_o),
        .issue_regread_o(issue_regread_o),
        .commit_valid_i(commit_valid_i), .commit_id_i(commit_id_i), .commit_kill_i(commit_kill_i),
        .result_valid_o(result_valid_o), .result_ready_i(result_ready_i),
        .result_id_o(result_id_o), .result_rd_o(result_rd_o), .result_data_o(result_data_o),
        .result_we_o(result_we_o), .busy_o(busy_o)
    );

    always #5 clk_i = ~clk_i;

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic [31:0] instr;
        logic [31:0] rs1, rs2, rs3;
        logic [2:0]  rsv;
        logic        acc, wb;
        logic [2:0]  rr;
        logic        rdy;
        logic [31:0] data;
    } vec_t;

    vec_t vecs [12];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic drive_issue(input logic [31:0] instr, input logic [2:0] id,
                               input logic [31:0] a, input logic [31:0] b,
                               input logic [31:0] c, input logic [2:0] rsv);
        issue_valid_i    = 1'b1;
        issue_instr_i    = instr;
        issue_id_i       = id;
        issue_rs_i       = {c, b, a};
        issue_rs_valid_i = rsv;
    endtask

    task automatic commit(input logic [2:0] id, input logic kill);
        commit_valid_i = 1'b1;
        commit_id_i    = id;
        commit_kill_i  = kill;
    endtask

    task automatic idle_inputs();
        issue_valid_i  = 1'b0;
        commit_valid_i = 1'b0;
        commit_kill_i  = 1'b0;
    endtask

    // Bounded wait for a result; checks it and lets the pop edge pass (result_ready_i must be 1)
    task automatic expect_result(input logic [2:0] id, input logic [31:0] data);
        int k = 0;
        while (!result_valid_o && k < 20) begin
            step();
            k++;
        end
        chk("res_valid", 64'(result_valid_o), 64'(1));
        chk("res_id", 64'(result_id_o), 64'(id));
        chk("res_data", 64'(result_data_o), 64'(data));
        step();
    endtask

    initial begin
        logic [2:0] id;
        logic       push;

        vecs[0]  = '{32'h000012FB, 32'hFFFFFFFF, 32'h2, 32'h0, 3'b111, 1, 1, 3'b011, 1, 32'h00000001};
        vecs[1]  = '{32'h020010FB, 32'h80000001, 32'h5, 32'h0, 3'b111, 1, 1, 3'b001, 1, 32'h00000002};
        vecs[2]  = '{32'h0400117B, 32'h0, 32'h12345678, 32'h0, 3'b010, 1, 1, 3'b010, 1, 32'h2468ACF0};
        vecs[3]  = '{32'h080011FB, 32'h10, 32'h20, 32'hFFFFFFFF, 3'b111, 1, 1, 3'b111, 1, 32'h0000002F};
        vecs[4]  = '{32'h0800020B, 32'h1, 32'h0, 32'h0, 3'b011, 1, 1, 3'b011, 1, 32'h00000000};
        vecs[5]  = '{32'h0800130B, 32'h1, 32'h0, 32'h0, 3'b011, 1, 1, 3'b011, 1, 32'h10000000};
        vecs[6]  = '{32'h0000138B, 32'hAAAA0000, 32'h12345678, 32'h0, 3'b011, 1, 1, 3'b011, 1, 32'h12345678};
        vecs[7]  = '{32'h4800008B, 32'hDEADBEEF, 32'h01234567, 32'h0, 3'b011, 1, 1, 3'b011, 1, 32'hF0123456};
        vecs[8]  = '{32'h00000013, 32'h0, 32'h0, 32'h0, 3'b000, 0, 0, 3'b000, 1, 32'h0};
        vecs[9]  = '{32'h0000007B, 32'h0, 32'h0, 32'h0, 3'b111, 1, 0, 3'b000, 1, 32'h0};
        vecs[10] = '{32'h000012FB, 32'h1, 32'h1, 32'h0, 3'b001, 1, 1, 3'b011, 0, 32'h0};
        vecs[11] = '{32'h0000007B, 32'h0, 32'h0, 32'h0, 3'b000, 1, 0, 3'b000, 1, 32'h0};

        rst_ni         = 1'b0;
        issue_instr_i  = '0;
        issue_id_i     = '0;
        issue_rs_i     = '0;
        issue_rs_valid_i = '0;
        commit_id_i    = '0;
        result_ready_i = 1'b0;
        idle_inputs();
        step();
        step();
        chk("rst_ready", 64'(issue_ready_o), 64'(0));
        chk("rst_res_valid", 64'(result_valid_o), 64'(0));
        chk("rst_busy", 64'(busy_o), 64'(0));
        chk("rst_res_we", 64'(result_we_o), 64'(0));
        chk("rst_res_data", 64'(result_data_o), 64'(0));
        rst_ni = 1'b1;
        step();

        // Decode/execute table: commit in the issue cycle, result exactly EXEC_LAT edges later
        result_ready_i = 1'b1;
        for (int i = 0; i < 12; i++) begin
            id = 3'(i);
            drive_issue(vecs[i].instr, id, vecs[i].rs1, vecs[i].rs2, vecs[i].rs3, vecs[i].rsv);
            commit(id, 1'b0);
            #1;
            chk($sformatf("v%0d_accept", i), 64'(issue_accept_o), 64'(vecs[i].acc));
            chk($sformatf("v%0d_wb", i), 64'(issue_writeback_o), 64'(vecs[i].wb));
            chk($sformatf("v%0d_regread", i), 64'(issue_regread_o), 64'(vecs[i].rr));
            chk($sformatf("v%0d_ready", i), 64'(issue_ready_o), 64'(vecs[i].rdy));
            push = vecs[i].rdy & vecs[i].acc & vecs[i].wb;
            step();
            idle_inputs();
            chk($sformatf("v%0d_busy", i), 64'(busy_o), 64'(push));
            if (push) begin
                step();
                chk($sformatf("v%0d_early", i), 64'(result_valid_o), 64'(0));
                step();
                chk($sformatf("v%0d_res_valid", i), 64'(result_valid_o), 64'(1));
                chk($sformatf("v%0d_res_data", i), 64'(result_data_o), 64'(vecs[i].data));
                chk($sformatf("v%0d_res_rd", i), 64'(result_rd_o), 64'(vecs[i].instr[11:7]));
                chk($sformatf("v%0d_res_id", i), 64'(result_id_o), 64'(id));
                chk($sformatf("v%0d_res_we", i), 64'(result_we_o), 64'(1));
            end
            step();
            chk($sformatf("v%0d_drained", i), 64'(busy_o), 64'(0));
            chk($sformatf("v%0d_no_res", i), 64'(result_valid_o), 64'(0));
        end

        // Fill with result_ready low; duplicate id and full buffer both block issue
        result_ready_i = 1'b0;
        drive_issue(32'h0000107B, 3'd0, 32'd1, 32'd1, 32'd0, 3'b111);
        #1 chk("fill_ready0", 64'(issue_ready_o), 64'(1));
        step();
        drive_issue(32'h0000107B, 3'd0, 32'd7, 32'd7, 32'd0, 3'b111);
        #1 chk("reuse_id_ready", 64'(issue_ready_o), 64'(0));
        for (int i = 1; i < 4; i++) begin
            drive_issue(32'h0000107B, 3'(i), 32'(i), 32'd2, 32'd0, 3'b111);
            #1 chk($sformatf("fill_ready%0d", i), 64'(issue_ready_o), 64'(1));
            step();
        end
        drive_issue(32'h0000107B, 3'd4, 32'd9, 32'd9, 32'd0, 3'b111);
        #1 chk("full_ready", 64'(issue_ready_o), 64'(0));
        commit(3'd0, 1'b0);
        step();
        commit_valid_i = 1'b0;
        chk("full_head_valid", 64'(result_valid_o), 64'(1));
        chk("full_head_data", 64'(result_data_o), 64'(2));
        step();
        chk("hold_valid", 64'(result_valid_o), 64'(1));
        chk("hold_data", 64'(result_data_o), 64'(2));
        chk("hold_id", 64'(result_id_o), 64'(0));
        result_ready_i = 1'b1;
        #1 chk("pop_no_bypass", 64'(issue_ready_o), 64'(0));
        step();
        result_ready_i = 1'b0;
        chk("after_pop_ready", 64'(issue_ready_o), 64'(1));
        idle_inputs();
        for (int i = 1; i < 4; i++) begin
            commit(3'(i), 1'b0);
            step();
        end
        idle_inputs();
        result_ready_i = 1'b1;
        expect_result(3'd1, 32'd3);
        expect_result(3'd2, 32'd4);
        expect_result(3'd3, 32'd5);
        chk("fill_drained", 64'(busy_o), 64'(0));

        // Kill a middle entry: only ids 1 and 3 come back, in order
        result_ready_i = 1'b0;
        for (int i = 1; i < 4; i++) begin
            drive_issue(32'h0000107B, 3'(i), 32'(i * 16), 32'd1, 32'd0, 3'b111);
            step();
        end
        idle_inputs();
        commit(3'd2, 1'b1); step();
        commit(3'd1, 1'b0); step();
        commit(3'd3, 1'b0); step();
        idle_inputs();
        result_ready_i = 1'b1;
        expect_result(3'd1, 32'd17);
        expect_result(3'd3, 32'd49);
        chk("kill_no_extra", 64'(result_valid_o), 64'(0));
        chk("kill_drained", 64'(busy_o), 64'(0));

        // Kill of the current head is popped in the kill cycle itself
        drive_issue(32'h0000107B, 3'd5, 32'd1, 32'd1, 32'd0, 3'b111);
        step();
        idle_inputs();
        chk("head_kill_busy_before", 64'(busy_o), 64'(1));
        commit(3'd5, 1'b1);
        step();
        idle_inputs();
        chk("head_kill_busy_after", 64'(busy_o), 64'(0));
        step();
        chk("head_kill_no_res", 64'(result_valid_o), 64'(0));

        // Reset with three committed entries in flight and a result presented
        result_ready_i = 1'b0;
        for (int i = 1; i < 4; i++) begin
            drive_issue(32'h0000107B, 3'(i), 32'd5, 32'(i), 32'd0, 3'b111);
            commit(3'(i), 1'b0);
            step();
        end
        idle_inputs();
        step();
        chk("pre_rst_valid", 64'(result_valid_o), 64'(1));
        #2 rst_ni = 1'b0;
        #1;
        chk("mid_rst_valid", 64'(result_valid_o), 64'(0));
        chk("mid_rst_busy", 64'(busy_o), 64'(0));
        chk("mid_rst_data", 64'(result_data_o), 64'(0));
        chk("mid_rst_id", 64'(result_id_o), 64'(0));
        chk("mid_rst_rd", 64'(result_rd_o), 64'(0));
        chk("mid_rst_we", 64'(result_we_o), 64'(0));
        step();
        rst_ni = 1'b1;
        result_ready_i = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            chk($sformatf("post_rst_valid%0d", i), 64'(result_valid_o), 64'(0));
        end
        chk("post_rst_busy", 64'(busy_o), 64'(0));
        drive_issue(32'h0000107B, 3'd1, 32'd1, 32'd1, 32'd0, 3'b111);
        #1 chk("post_rst_id_free", 64'(issue_ready_o), 64'(1));
        idle_inputs();
        step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
